// File: rtl/rgmii_rx_deframer.sv
// RGMII receive deframer: DDR nibble capture, preamble/SFD stripping and
// delivery of a byte stream with last/error/length to the MAC receive logic.
module rgmii_rx_deframer #(
    parameter int unsigned MIN_PREAMBLE = 1,
    parameter int unsigned MAX_LEN      = 1522,
    parameter int unsigned LEN_WIDTH    = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [3:0]           rgmii_rxd,
    input  logic                 rgmii_rx_ctl,
    output logic [7:0]           m_data,
    output logic                 m_valid,
    output logic                 m_last,
    output logic                 m_err,
    output logic [LEN_WIDTH-1:0] m_len,
    output logic [15:0]          drop_cnt
);

    localparam logic [7:0]           PRE_MIN = 8'(MIN_PREAMBLE);
    localparam logic [LEN_WIDTH-1:0] LEN_MAX = LEN_WIDTH'(MAX_LEN);

    typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_DATA, S_DROP} state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [3:0]           lo_q;
    logic [3:0]           hi_q;
    logic                 dv_q;
    logic                 c2_q;
    logic [7:0]           byte_q;
    logic                 bdv_q;
    logic                 ber_q;

    state_t               state;
    logic [7:0]           pre_cnt;
    logic [7:0]           hold;
    logic                 hold_vld;
    logic                 err;
    logic                 armed;
    logic [LEN_WIDTH-1:0] len;

    // Rising-edge capture of low nibble/RX_DV and assembly of the previous byte
    always_ff @(posedge clk) begin
        lo_q   <= rgmii_rxd;
        dv_q   <= rgmii_rx_ctl;
        byte_q <= {hi_q, lo_q};
        bdv_q  <= dv_q;
        ber_q  <= dv_q ^ c2_q;
    end

    // Falling-edge capture of high nibble and RX_DV^RX_ER
    always_ff @(negedge clk) begin
        hi_q <= rgmii_rxd;
        c2_q <= rgmii_rx_ctl;
    end

    // Frame FSM; 'armed' keeps a frame already in flight at reset from being parsed
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            pre_cnt  <= 8'd0;
            hold     <= 8'd0;
            hold_vld <= 1'b0;
            err      <= 1'b0;
            armed    <= 1'b0;
            len      <= '0;
            m_data   <= 8'd0;
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            m_err    <= 1'b0;
            m_len    <= '0;
            drop_cnt <= 16'd0;
        end else begin
            m_valid <= 1'b0;
            m_last  <= 1'b0;
            m_err   <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!bdv_q) begin
                        armed <= 1'b1;
                    end else if (!armed) begin
                        state    <= S_DROP;
                        drop_cnt <= sat_inc(drop_cnt);
                    end else if (byte_q == 8'h55) begin
                        state   <= S_PREAMBLE;
                        pre_cnt <= 8'd1;
                    end else if (byte_q == 8'hD5 && PRE_MIN == 8'd0) begin
                        state    <= S_DATA;
                        hold_vld <= 1'b0;
                        err      <= 1'b0;
                        len      <= '0;
                    end else begin
                        state    <= S_DROP;
                        drop_cnt <= sat_inc(drop_cnt);
                    end
                end
                S_PREAMBLE: begin
                    if (!bdv_q) begin
                        state    <= S_IDLE;
                        drop_cnt <= sat_inc(drop_cnt);
                    end else if (byte_q == 8'h55) begin
                        if (pre_cnt < PRE_MIN) pre_cnt <= pre_cnt + 8'd1;
                    end else if (byte_q == 8'hD5 && pre_cnt >= PRE_MIN) begin
                        state    <= S_DATA;
                        hold_vld <= 1'b0;
                        err      <= 1'b0;
                        len      <= '0;
                    end else begin
                        state    <= S_DROP;
                        drop_cnt <= sat_inc(drop_cnt);
                    end
                end
                S_DATA: begin
                    if (bdv_q) begin
                        if (hold_vld && len == LEN_MAX) begin
                            // Truncate: the held byte is the MAX_LEN-th one
                            m_data   <= hold;
                            m_valid  <= 1'b1;
                            m_last   <= 1'b1;
                            m_err    <= 1'b1;
                            m_len    <= LEN_MAX;
                            hold_vld <= 1'b0;
                            state    <= S_DROP;
                        end else begin
                            if (hold_vld) begin
                                m_data  <= hold;
                                m_valid <= 1'b1;
                            end
                            hold     <= byte_q;
                            hold_vld <= 1'b1;
                            len      <= len + {{(LEN_WIDTH-1){1'b0}}, 1'b1};
                            err      <= err | ber_q;
                        end
                    end else begin
                        if (hold_vld) begin
                            m_data  <= hold;
                            m_valid <= 1'b1;
                            m_last  <= 1'b1;
                            m_err   <= err;
                            m_len   <= len;
                        end else begin
                            drop_cnt <= sat_inc(drop_cnt);
                        end
                        hold_vld <= 1'b0;
                        state    <= S_IDLE;
                    end
                end
                S_DROP: begin
                    if (!bdv_q) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/rgmii_rx_deframer.md
Name: rgmii_rx_deframer

Overview:
- Receive-side counterpart of the RGMII transmit DDR output stage.
- Samples the 4-bit DDR RGMII receive bus on both edges of the receive clock and reassembles bytes.
- Recovers RX_DV/RX_ER, strips preamble and SFD, and emits a byte stream with valid/last/error and frame length to the MAC receive logic.
- No backpressure: the line cannot be stalled, so downstream must accept one byte per cycle.

Parameters:
- MIN_PREAMBLE, 1: minimum count of 0x55 bytes required before SFD; fewer causes the frame to be dropped.
- MAX_LEN, 1522: maximum post-SFD bytes accepted; longer frames are truncated and flagged.
- LEN_WIDTH, 11: width of m_len; must hold MAX_LEN.

Ports:
- clk  input  1  RGMII receive clock; the block's only clock; both edges used for capture.
- rst  input  1  synchronous, active-high reset, sampled on posedge clk.
- rgmii_rxd  input  4  DDR data: low nibble on rising edge, high nibble on falling edge.
- rgmii_rx_ctl  input  1  DDR control: RX_DV on rising edge, RX_DV^RX_ER on falling edge.
- m_data  output  8  received payload byte (first byte after SFD onward).
- m_valid  output  1  m_data valid this cycle.
- m_last  output  1  final byte of frame; asserted only with m_valid.
- m_err  output  1  frame error; meaningful only with m_last.
- m_len  output  LEN_WIDTH  byte count of delivered frame, valid with m_last.
- drop_cnt  output  16  count of frames discarded with no output; saturates at 0xFFFF.

Behaviour:
Capture stage:
- posedge: lo_q<=rxd, dv_q<=ctl.
- negedge: hi_q<=rxd, c2_q<=ctl.
- next posedge: byte_q<={hi_q,lo_q}, bdv_q<=dv_q, ber_q<=dv_q^c2_q.
- A byte whose low nibble is sampled at rising edge N is visible in byte_q after edge N+1.

Hold buffer:
- Each accepted data byte is held one cycle so m_last can mark it when bdv_q drops.
- End-to-end latency: a payload byte sampled at edge N appears on m_data after edge N+3.

FSM (evaluated on posedge using byte_q/bdv_q/ber_q):
- IDLE: bdv_q=0 -> stay.
  - bdv_q=1 and byte=0x55 -> PREAMBLE, pre_cnt=1.
  - bdv_q=1 and byte=0xD5 and MIN_PREAMBLE=0 -> DATA.
  - bdv_q=1 otherwise -> DROP.
- PREAMBLE: byte=0x55 -> pre_cnt++ (saturating at MIN_PREAMBLE).
  - byte=0xD5 -> DATA if pre_cnt>=MIN_PREAMBLE, else DROP.
  - Any other byte -> DROP.
  - bdv_q falls -> IDLE, drop_cnt++.
- DATA: each byte with bdv_q=1 loads the hold buffer; the previous hold content is emitted with m_valid=1, m_last=0.
  - len increments on each delivered byte.
  - ber_q=1 on any data byte sets a sticky err flag.
  - bdv_q falls -> emit hold byte with m_last=1, m_err=err, m_len=total count -> IDLE.
  - bdv_q falls with zero bytes after SFD -> no output, drop_cnt++, IDLE.
- Overflow: the byte count reaching MAX_LEN with bdv_q still 1 -> emit the MAX_LEN-th byte with m_last=1, m_err=1, m_len=MAX_LEN -> DROP.
- DROP: discard all bytes; bdv_q falls -> IDLE.
  - drop_cnt++ once per frame, on entry to DROP from IDLE or PREAMBLE only. Overflow frames are not counted.
- ber_q with bdv_q=0 (false carrier / in-band status) is ignored.

Outputs and reset:
- m_valid, m_last, m_err are single-cycle pulses, registered, and deassert the cycle after emission.
- rst: FSM->IDLE; the hold buffer, err, len and pre_cnt are cleared. m_data=0, m_valid=0, m_last=0, m_err=0, m_len=0, drop_cnt=0.
  - A frame in progress at reset produces no m_last.
  - If bdv_q=1 on the first post-reset cycle, the FSM treats the byte as a non-preamble start -> DROP.
- Back-to-back frames with a 1-cycle dv gap are handled: the hold buffer flushes during the gap.

Test Plan:
- 7x0x55, 0xD5, payload 0x01..0x3C (60 B), dv low -> 60 m_valid beats with m_data=0x01..0x3C in order; m_last on 0x3C, m_err=0, m_len=60; first beat arrives exactly 3 cycles after 0x01 low-nibble edge.
- Same frame with RX_ER asserted on payload byte 10 (ctl falling = 0) -> all 60 bytes delivered; m_last with m_err=1, m_len=60.
- MIN_PREAMBLE=4, stimulus 2x0x55, 0xD5, 20 B -> no m_valid, drop_cnt=1; a following good frame is delivered intact.
- MAX_LEN=64, 100-byte payload -> 64 beats, m_last on beat 64 with m_err=1, m_len=64; remaining 36 bytes discarded; the next frame is received normally; drop_cnt=0.
- Preamble, SFD, then dv low immediately -> no output, drop_cnt=1. Two 8-byte frames separated by a 1-cycle dv gap -> two complete frames, each m_len=8, m_last on the correct byte.
- rst pulsed mid-payload (byte 30 of 60) -> outputs zero next cycle, no m_last; the remainder of that frame is dropped (drop_cnt=1); the next frame is received correctly.
